eq_sequencer: RTL and testbench
===============================

EQ_SEQUENCER -- requirements
Module: eq_sequencer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset: synchronous, active-low; clock clk.
REQ-003 SHALL have port address  input  6  CPU register address.
REQ-004 SHALL have port data_in  input  32  CPU write data.
REQ-005 SHALL have port data_write_n  input  2  11 = no write, 00/01/10 = 8/16/32-bit write.
REQ-006 SHALL have port data_read_n  input  2  11 = no read, else read.
REQ-007 SHALL have port data_out  output  32  CPU read data.
REQ-008 SHALL have port data_ready  output  1  tied 1.
REQ-009 SHALL have port user_interrupt  output  1  level interrupt.
REQ-010 SHALL have port eq_address  output  6  equalizer register address.
REQ-011 SHALL have port eq_data_in  output  32  equalizer write data.
REQ-012 SHALL have port eq_data_write_n  output  2  equalizer write strobe.
REQ-013 SHALL have port eq_data_out  input  32  equalizer combinational read data.
REQ-014 SHALL use parameter FIFO_DEPTH, default 4, depth of each FIFO (power of 2).

Function
REQ-015 Register map SHALL be: 0x00 CTRL {bit0 en, bit1 irq_en, bit2 flush (write-only, self-clearing)}; 0x04 DIV[15:0] sample period in clocks; 0x08 IN push (write data[15:0]); 0x0C OUT pop (read, sign-extended 16-bit); 0x10 STATUS {[3:0] in_cnt, [7:4] out_cnt, bit8 in_ovf, bit9 underrun, bit10 out_ovr}, sticky bits cleared by write-1.
REQ-016 Reads of unmapped addresses SHALL return 0; 0x08 reads SHALL return 0.
REQ-017 Effective period SHALL be max(DIV,4); timer SHALL count down only while en=1 and SHALL reload and emit one-cycle tick on reaching 0.
REQ-018 FSM states SHALL be IDLE, WRITE, WAIT, CAPTURE, each one cycle except IDLE.
REQ-019 On tick in IDLE with in_cnt>0 and out_cnt<FIFO_DEPTH, FSM SHALL go to WRITE and pop the IN head.
REQ-020 WRITE: eq_address=0x08, eq_data_write_n=01, eq_data_in=sign-extended sample; all other states: eq_data_write_n=11.
REQ-021 WAIT and CAPTURE: eq_address=0x00; IDLE: eq_address=0x00, eq_data_in=0.
REQ-022 CAPTURE SHALL push eq_data_out[15:0] into OUT at cycle end, then go to IDLE; sample-to-OUT latency = 3 cycles after tick.
REQ-023 Tick with in_cnt=0 SHALL set underrun; tick with OUT full SHALL set out_ovr and leave IN unchanged; neither starts a sequence.
REQ-024 CPU push to full IN SHALL be dropped and set in_ovf.
REQ-025 CPU pop (read 0x0C) of empty OUT SHALL return 0 and change nothing.
REQ-026 Simultaneous CPU push and sequencer pop on IN, and simultaneous sequencer push and CPU pop on OUT, SHALL both take effect; counts consistent.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Writing flush=1 SHALL empty both FIFOs, reload timer, force FSM to IDLE next cycle, keep en/irq_en/DIV from same write.
REQ-029 Clearing en mid-sequence SHALL let the current sequence complete.
REQ-030 user_interrupt SHALL = irq_en & (out_cnt>0 | in_ovf | underrun | out_ovr).

Reset
REQ-031 On rst_n=0 at clk edge: CTRL=0, DIV=0, FIFOs empty, sticky flags 0, timer=4, FSM IDLE.
REQ-032 During and after reset until first write: user_interrupt=0, eq_data_write_n=11, eq_address=0, eq_data_in=0, data_out per address (STATUS=0).
REQ-033 Reset mid-sequence SHALL abort with no OUT push.

Verification
REQ-034 DIV=10, push 0x1234, en=1 -> one eq write of 0x00001234 to 0x08 at tick; OUT holds equalizer yout 3 cycles later; out_cnt=1.
REQ-035 Push 5 samples with en=0 -> in_cnt=4, in_ovf=1; write STATUS 0x100 -> in_ovf=0.
REQ-036 en=1, IN empty, DIV=4 -> underrun=1 after 4 cycles; irq_en=1 -> user_interrupt=1.
REQ-037 Fill OUT (4 samples), keep ticking -> out_ovr=1, in_cnt unchanged; pop one -> next tick resumes.
REQ-038 Push and OUT pop on same cycle as sequencer pop/push -> counts unchanged net, data order preserved FIFO.
REQ-039 Flush in WAIT state -> FIFOs empty, FSM IDLE next cycle, no OUT push; reset mid-WRITE -> all REQ-031 values.

Source files
------------

// File: rtl/eq_sequencer.sv
// Equalizer sample sequencer: CPU-facing IN/OUT sample FIFOs feed an equalizer core one sample
// per timer tick through a WRITE/WAIT/CAPTURE sequence.
module eq_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic [5:0]  eq_address,
  output logic [31:0] eq_data_in,
  output logic [1:0]  eq_data_write_n,
  input  logic [31:0] eq_data_out
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StWait, StCapture} state_e;

  state_e            state_q, state_d;
  logic              en_q, en_d, irq_en_q, irq_en_d;
  logic [15:0]       div_q, div_d, timer_q, timer_d, sample_q, sample_d;
  logic              in_ovf_q, in_ovf_d, underrun_q, underrun_d, out_ovr_q, out_ovr_d;
  logic [15:0]       in_mem [FIFO_DEPTH];
  logic [15:0]       out_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   in_wr_q, in_wr_d, in_rd_q, in_rd_d, out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CntW-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

  logic              wr_en, rd_en, wr_ctrl, wr_div, wr_in, wr_status, flush;
  logic [15:0]       wmask, wdata, period;
  logic              tick, start, in_push, in_pop, out_push, out_pop, in_full, out_full;
  logic              unused_bits;

  assign unused_bits = ^{data_in[31:16], eq_data_out[31:16]};
  assign data_ready  = 1'b1;

  // Byte writes only touch the low byte; halfword and word writes cover every mapped field.
  assign wmask     = (data_write_n == 2'b00) ? 16'h00ff : 16'hffff;
  assign wdata     = data_in[15:0] & wmask;
  assign wr_en     = (data_write_n != 2'b11);
  assign rd_en     = (data_read_n != 2'b11);
  assign wr_ctrl   = wr_en && (address == 6'h00);
  assign wr_div    = wr_en && (address == 6'h04);
  assign wr_in     = wr_en && (address == 6'h08);
  assign wr_status = wr_en && (address == 6'h10);
  assign flush     = wr_ctrl && wdata[2];

  assign in_full  = (in_cnt_q == CntFull);
  assign out_full = (out_cnt_q == CntFull);
  assign period   = (div_q < 16'd4) ? 16'd4 : div_q;
  assign tick     = en_q && (timer_q == 16'd1);
  assign start    = tick && !flush && (state_q == StIdle) && (in_cnt_q != '0) && !out_full;

  assign in_push  = wr_in && !in_full;
  assign in_pop   = start;
  assign out_push = (state_q == StCapture) && !out_full && !flush;
  assign out_pop  = rd_en && (address == 6'h0c) && (out_cnt_q != '0);

  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    div_d      = div_q;
    timer_d    = timer_q;
    sample_d   = start ? in_mem[in_rd_q] : sample_q;
    state_d    = state_q;
    in_ovf_d   = in_ovf_q;
    underrun_d = underrun_q;
    out_ovr_d  = out_ovr_q;

    if (wr_ctrl) begin
      en_d     = wdata[0];
      irq_en_d = wdata[1];
    end
    if (wr_div) div_d = (div_q & ~wmask) | wdata;

    if (flush)         timer_d = period;
    else if (tick)     timer_d = period;
    else if (en_q)     timer_d = timer_q - 16'd1;

    if (wr_status) begin
      in_ovf_d   = in_ovf_q & ~wdata[8];
      underrun_d = underrun_q & ~wdata[9];
      out_ovr_d  = out_ovr_q & ~wdata[10];
    end
    if (wr_in && in_full)                            in_ovf_d   = 1'b1;
    if (tick && !flush && (in_cnt_q == '0))          underrun_d = 1'b1;
    if (tick && !flush && out_full)                  out_ovr_d  = 1'b1;

    case (state_q)
      StIdle:    if (start) state_d = StWrite;
      StWrite:   state_d = StWait;
      StWait:    state_d = StCapture;
      default:   state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;

    in_wr_d   = in_wr_q + PtrW'(in_push);
    in_rd_d   = in_rd_q + PtrW'(in_pop);
    in_cnt_d  = in_cnt_q + CntW'(in_push) - CntW'(in_pop);
    out_wr_d  = out_wr_q + PtrW'(out_push);
    out_rd_d  = out_rd_q + PtrW'(out_pop);
    out_cnt_d = out_cnt_q + CntW'(out_push) - CntW'(out_pop);
    if (flush) begin
      in_wr_d   = '0;
      in_rd_d   = '0;
      in_cnt_d  = '0;
      out_wr_d  = '0;
      out_rd_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= '0;
      timer_q    <= 16'd4;
      sample_q   <= '0;
      in_ovf_q   <= 1'b0;
      underrun_q <= 1'b0;
      out_ovr_q  <= 1'b0;
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      in_cnt_q   <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      div_q      <= div_d;
      timer_q    <= timer_d;
      sample_q   <= sample_d;
      in_ovf_q   <= in_ovf_d;
      underrun_q <= underrun_d;
      out_ovr_q  <= out_ovr_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and counts.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_q]   <= wdata;
    if (out_push) out_mem[out_wr_q] <= eq_data_out[15:0];
  end

  always_comb begin
    data_out = '0;
    case (address)
      6'h00: data_out = {30'b0, irq_en_q, en_q};
      6'h04: data_out = {16'b0, div_q};
      6'h0c: if (out_cnt_q != '0) data_out = {{16{out_mem[out_rd_q][15]}}, out_mem[out_rd_q]};
      6'h10: data_out = {21'b0, out_ovr_q, underrun_q, in_ovf_q, 4'(out_cnt_q), 4'(in_cnt_q)};
      default: data_out = '0;
    endcase
  end

  always_comb begin
    eq_address      = 6'h00;
    eq_data_in      = '0;
    eq_data_write_n = 2'b11;
    if (state_q == StWrite) begin
      eq_address      = 6'h08;
      eq_data_in      = {{16{sample_q[15]}}, sample_q};
      eq_data_write_n = 2'b01;
    end
  end

  assign user_interrupt = irq_en_q & ((out_cnt_q != '0) | in_ovf_q | underrun_q | out_ovr_q);

endmodule

// File: tb/tb_eq_sequencer.sv
// Self-checking bench for eq_sequencer; a toy equalizer (y = 3x + 0x11) supplies capture data
// and a scoreboard queue holds the expected OUT FIFO contents.
module tb_eq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic [5:0]  eq_address;
  logic [31:0] eq_data_in;
  logic [1:0]  eq_data_write_n;
  logic [31:0] eq_data_out;
  logic [15:0] eq_reg = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  eq_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .eq_address     (eq_address),
    .eq_data_in     (eq_data_in),
    .eq_data_write_n(eq_data_write_n),
    .eq_data_out    (eq_data_out)
  );

  function automatic logic [15:0] eq_fn(input logic [15:0] x);
    logic [15:0] y;
    y = x * 16'd3 + 16'h0011;
    return y;
  endfunction

  function automatic logic [31:0] exp_out(input logic [15:0] x);
    logic [15:0] y;
    y = eq_fn(x);
    return {{16{y[15]}}, y};
  endfunction

  always @(posedge clk)
    if (eq_data_write_n == 2'b01 && eq_address == 6'h08) eq_reg <= eq_fn(eq_data_in[15:0]);
  assign eq_data_out = {16'ha5a5, eq_reg};

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    address = '0;
    data_in = '0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write_n = 2'b10;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a;
    data_read_n = 2'b00;
    #1 v = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1 v = data_out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    peek(6'h10, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_status got=%h exp=%h", v, 32'h0); else n_pass++;
    peek(6'h00, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_ctrl got=%h exp=%h", v, 32'h0); else n_pass++;
    peek(6'h04, v);
    n_checks++; if (v !== 32'h0) $display("FAIL reset_div got=%h exp=%h", v, 32'h0); else n_pass++;
    peek(6'h3c, v);
    n_checks++; if (v !== 32'h0) $display("FAIL unmapped_read got=%h exp=%h", v, 32'h0); else n_pass++;
    n_checks++; if (user_interrupt !== 1'b0) $display("FAIL reset_irq got=%b exp=0", user_interrupt); else n_pass++;
    n_checks++; if (data_ready !== 1'b1) $display("FAIL data_ready got=%b exp=1", data_ready); else n_pass++;
    n_checks++;
    if (eq_data_write_n !== 2'b11 || eq_address !== 6'h0 || eq_data_in !== 32'h0)
      $display("FAIL reset_eq_bus got=%b/%h/%h exp=11/00/0", eq_data_write_n, eq_address, eq_data_in);
    else n_pass++;
  endtask

  task automatic test_single_sample();
    logic [31:0] v, exp;
    bit found = 0;
    do_reset();
    cpu_write(6'h04, 32'd10);
    cpu_write(6'h08, 32'h1234);
    sb.push_back(exp_out(16'h1234));
    v = 0;
    peek(6'h08, v);
    n_checks++; if (v !== 32'h0) $display("FAIL in_reg_read got=%h exp=0", v); else n_pass++;
    cpu_write(6'h00, 32'h1);
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (eq_data_write_n == 2'b01) found = 1;
    end
    n_checks++; if (!found) $display("FAIL eq_write_seen got=0 exp=1"); else n_pass++;
    n_checks++;
    if (eq_address !== 6'h08 || eq_data_in !== 32'h0000_1234)
      $display("FAIL eq_write_bus got=%h/%h exp=08/00001234", eq_address, eq_data_in);
    else n_pass++;
    @(negedge clk);
    peek(6'h10, v);
    n_checks++;
    if (eq_data_write_n !== 2'b11 || v[7:4] !== 4'd0)
      $display("FAIL wait_state got=%b/%0d exp=11/0", eq_data_write_n, v[7:4]);
    else n_pass++;
    @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v[7:4] !== 4'd0) $display("FAIL capture_latency got=%0d exp=0", v[7:4]); else n_pass++;
    @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v !== 32'h010) $display("FAIL single_status got=%h exp=%h", v, 32'h010); else n_pass++;
    cpu_write(6'h00, 32'h0);
    cpu_read(6'h0c, v);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    n_checks++; if (v !== exp) $display("FAIL single_out got=%h exp=%h", v, exp); else n_pass++;
  endtask

  task automatic test_in_overflow();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) cpu_write(6'h08, 32'h100 + i);
    peek(6'h10, v);
    n_checks++; if (v !== 32'h104) $display("FAIL in_ovf_status got=%h exp=%h", v, 32'h104); else n_pass++;
    cpu_write(6'h00, 32'h2);
    n_checks++; if (user_interrupt !== 1'b1) $display("FAIL irq_in_ovf got=%b exp=1", user_interrupt); else n_pass++;
    cpu_write(6'h10, 32'h100);
    peek(6'h10, v);
    n_checks++; if (v !== 32'h004) $display("FAIL in_ovf_clear got=%h exp=%h", v, 32'h004); else n_pass++;
    n_checks++; if (user_interrupt !== 1'b0) $display("FAIL irq_after_clear got=%b exp=0", user_interrupt); else n_pass++;
  endtask

  task automatic test_underrun();
    logic [31:0] v;
    do_reset();
    cpu_write(6'h04, 32'd4);
    cpu_write(6'h00, 32'h3);
    repeat (3) @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v[9] !== 1'b0) $display("FAIL underrun_early got=%b exp=0", v[9]); else n_pass++;
    @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v[9] !== 1'b1) $display("FAIL underrun_set got=%b exp=1", v[9]); else n_pass++;
    n_checks++; if (user_interrupt !== 1'b1) $display("FAIL irq_underrun got=%b exp=1", user_interrupt); else n_pass++;
    cpu_write(6'h00, 32'h2);
    cpu_write(6'h10, 32'h200);
    n_checks++; if (user_interrupt !== 1'b0) $display("FAIL irq_underrun_clear got=%b exp=0", user_interrupt); else n_pass++;
  endtask

  task automatic test_out_overrun();
    logic [31:0] v, exp;
    logic [15:0] smp [6];
    bit ok;
    smp[0] = 16'h8000; smp[1] = 16'h0001; smp[2] = 16'h7fff;
    smp[3] = 16'hfff0; smp[4] = 16'h0100; smp[5] = 16'h0200;
    do_reset();
    cpu_write(6'h04, 32'd4);
    for (int i = 0; i < 4; i++) begin
      cpu_write(6'h08, {16'h0, smp[i]});
      sb.push_back(exp_out(smp[i]));
    end
    cpu_write(6'h00, 32'h1);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      peek(6'h10, v);
      if (v[7:4] == 4'd4) ok = 1;
    end
    n_checks++; if (!ok) $display("FAIL out_fill got=%0d exp=4", v[7:4]); else n_pass++;
    for (int i = 4; i < 6; i++) begin
      cpu_write(6'h08, {16'h0, smp[i]});
      sb.push_back(exp_out(smp[i]));
    end
    repeat (12) @(negedge clk);
    peek(6'h10, v);
    n_checks++;
    if (v[3:0] !== 4'd2 || v[7:4] !== 4'd4 || v[10] !== 1'b1)
      $display("FAIL out_ovr_status got=%h exp=in2/out4/ovr1", v);
    else n_pass++;
    cpu_read(6'h0c, v);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    n_checks++; if (v !== exp) $display("FAIL ovr_pop0 got=%h exp=%h", v, exp); else n_pass++;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      peek(6'h10, v);
      if (v[7:4] == 4'd4) ok = 1;
    end
    n_checks++;
    if (!ok || v[3:0] !== 4'd1) $display("FAIL resume_after_pop got=%h exp=in1/out4", v);
    else n_pass++;
    cpu_write(6'h00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cpu_read(6'h0c, v);
      exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      n_checks++; if (v !== exp) $display("FAIL ovr_drain%0d got=%h exp=%h", i, v, exp); else n_pass++;
    end
    cpu_read(6'h0c, v);
    n_checks++; if (v !== 32'h0) $display("FAIL empty_pop got=%h exp=0", v); else n_pass++;
    peek(6'h10, v);
    n_checks++;
    if (v[7:0] !== 8'h01) $display("FAIL empty_pop_counts got=%h exp=01", v[7:0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, exp;
    do_reset();
    cpu_write(6'h04, 32'd4);
    for (int i = 0; i < 3; i++) begin
      cpu_write(6'h08, 32'h0010 + i);
      sb.push_back(exp_out(16'h0010 + 16'(i)));
    end
    cpu_write(6'h00, 32'h1);
    // Second tick lands in the cycle this push is presented.
    repeat (6) @(negedge clk);
    cpu_write(6'h08, 32'h0013);
    sb.push_back(exp_out(16'h0013));
    peek(6'h10, v);
    n_checks++; if (v[7:0] !== 8'h12) $display("FAIL b2b_in_counts got=%h exp=12", v[7:0]); else n_pass++;
    @(negedge clk);
    cpu_read(6'h0c, v);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    n_checks++; if (v !== exp) $display("FAIL b2b_pop got=%h exp=%h", v, exp); else n_pass++;
    peek(6'h10, v);
    n_checks++; if (v[7:0] !== 8'h12) $display("FAIL b2b_out_counts got=%h exp=12", v[7:0]); else n_pass++;
    cpu_write(6'h00, 32'h0);
    repeat (4) @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v !== 32'h021) $display("FAIL en_clear_completes got=%h exp=%h", v, 32'h021); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cpu_read(6'h0c, v);
      exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      n_checks++; if (v !== exp) $display("FAIL b2b_drain%0d got=%h exp=%h", i, v, exp); else n_pass++;
    end
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] v;
    do_reset();
    cpu_write(6'h04, 32'd4);
    cpu_write(6'h08, 32'h0042);
    cpu_write(6'h00, 32'h1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (eq_data_write_n !== 2'b01 || eq_data_in !== 32'h42)
      $display("FAIL flush_pre_write got=%b/%h exp=01/00000042", eq_data_write_n, eq_data_in);
    else n_pass++;
    cpu_write(6'h00, 32'h5);
    sb.delete();
    peek(6'h10, v);
    n_checks++; if (v !== 32'h0) $display("FAIL flush_status got=%h exp=0", v); else n_pass++;
    repeat (2) @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v[7:4] !== 4'd0) $display("FAIL flush_no_push got=%0d exp=0", v[7:4]); else n_pass++;
    peek(6'h00, v);
    n_checks++; if (v !== 32'h1) $display("FAIL flush_keeps_en got=%h exp=1", v); else n_pass++;
    cpu_write(6'h00, 32'h4);
    cpu_write(6'h08, 32'h0077);
    cpu_write(6'h00, 32'h3);
    repeat (4) @(negedge clk);
    n_checks++; if (eq_data_write_n !== 2'b01) $display("FAIL rst_pre_write got=%b exp=01", eq_data_write_n); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midrst_status got=%h exp=0", v); else n_pass++;
    peek(6'h00, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midrst_ctrl got=%h exp=0", v); else n_pass++;
    peek(6'h04, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midrst_div got=%h exp=0", v); else n_pass++;
    n_checks++;
    if (eq_data_write_n !== 2'b11 || eq_address !== 6'h0 || eq_data_in !== 32'h0 || user_interrupt !== 1'b0)
      $display("FAIL midrst_outputs got=%b/%h/%h/%b exp=11/00/0/0",
               eq_data_write_n, eq_address, eq_data_in, user_interrupt);
    else n_pass++;
    rst_n = 1'b1;
    sb.delete();
    repeat (5) @(negedge clk);
    peek(6'h10, v);
    n_checks++; if (v !== 32'h0) $display("FAIL midrst_no_push got=%h exp=0", v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_in_overflow();
    test_underrun();
    test_out_overrun();
    test_back_to_back();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
